// File: rtl/uart_program_loader.sv
// uart_program_loader: receives a framed program over a UART byte stream
// (0xA5, N, 4*N data bytes LSB-first per word, XOR checksum), writes each
// completed word into instruction memory and, once the checksum matches,
// releases the CPU from reset. A rejected frame parks in ERROR until a new
// sync byte arrives; a verified program stays resident until reset.
module uart_program_loader #(
    parameter int INSTR_MEM_DEPTH = 32,
    parameter int ADDR_W          = 5,
    parameter int TIMEOUT_CYCLES  = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              run_req,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              cpu_enable,
    output logic              load_done,
    output logic              load_err
);

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Word index / length counters must hold any 8-bit N and any address.
    localparam int IDX_W = (ADDR_W > 8) ? ADDR_W : 8;
    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    // Idle counter runs 0 .. TIMEOUT_CYCLES-1.
    localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_ZERO = TO_W'(0);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [31:0] DEPTH_LIMIT = 32'(INSTR_MEM_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_CHECK = 3'd3,
        ST_RUN   = 3'd4,
        ST_ERROR = 3'd5
    } state_t;

    state_t            state_r;
    state_t            state_n;
    logic [IDX_W-1:0]  len_r;
    logic [IDX_W-1:0]  word_idx_r;
    logic [1:0]        byte_idx_r;
    logic [23:0]       word_buf_r;
    logic [7:0]        chk_r;
    logic [TO_W-1:0]   idle_cnt_r;

    logic              sync_s;
    logic              len_ok_s;
    logic              last_word_s;
    logic              word_end_s;
    logic              in_frame_s;
    logic              timeout_s;
    logic              wr_fire_s;

    // Running checksum step: the frame check byte is the XOR of all data bytes.
    function automatic logic [7:0] xor_accumulate(input logic [7:0] acc,
                                                  input logic [7:0] data_byte);
        return acc ^ data_byte;
    endfunction

    // Decode helper conditions from the current byte and counters.
    always_comb begin
        sync_s      = rx_valid && (rx_data == SYNC_BYTE);
        len_ok_s    = (rx_data != 8'h00) && ({24'h000000, rx_data} <= DEPTH_LIMIT);
        last_word_s = ((word_idx_r + IDX_ONE) == len_r);
        word_end_s  = (byte_idx_r == 2'd3);
        in_frame_s  = (state_r == ST_LEN) || (state_r == ST_DATA) || (state_r == ST_CHECK);
        if (in_frame_s && !rx_valid && (idle_cnt_r == TO_LAST)) begin
            timeout_s = 1'b1;
        end else begin
            timeout_s = 1'b0;
        end
        if ((state_r == ST_DATA) && rx_valid && word_end_s) begin
            wr_fire_s = 1'b1;
        end else begin
            wr_fire_s = 1'b0;
        end
    end

    // Next-state logic for the frame parser.
    always_comb begin
        state_n = state_r;
        case (state_r)
            ST_IDLE: begin
                if (sync_s) begin
                    state_n = ST_LEN;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_LEN: begin
                if (rx_valid) begin
                    if (len_ok_s) begin
                        state_n = ST_DATA;
                    end else begin
                        state_n = ST_ERROR;
                    end
                end else if (timeout_s) begin
                    state_n = ST_ERROR;
                end else begin
                    state_n = ST_LEN;
                end
            end
            ST_DATA: begin
                if (rx_valid) begin
                    if (word_end_s && last_word_s) begin
                        state_n = ST_CHECK;
                    end else begin
                        state_n = ST_DATA;
                    end
                end else if (timeout_s) begin
                    state_n = ST_ERROR;
                end else begin
                    state_n = ST_DATA;
                end
            end
            ST_CHECK: begin
                if (rx_valid) begin
                    if (rx_data == chk_r) begin
                        state_n = ST_RUN;
                    end else begin
                        state_n = ST_ERROR;
                    end
                end else if (timeout_s) begin
                    state_n = ST_ERROR;
                end else begin
                    state_n = ST_CHECK;
                end
            end
            ST_RUN: begin
                state_n = ST_RUN;
            end
            ST_ERROR: begin
                if (sync_s) begin
                    state_n = ST_LEN;
                end else begin
                    state_n = ST_ERROR;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Inter-byte idle counter, active only while a frame is in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt_r <= TO_ZERO;
        end else if (in_frame_s && !rx_valid) begin
            idle_cnt_r <= idle_cnt_r + TO_ONE;
        end else begin
            idle_cnt_r <= TO_ZERO;
        end
    end

    // Frame bookkeeping: length, word/byte indices, partial word and checksum.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_r      <= IDX_ZERO;
            word_idx_r <= IDX_ZERO;
            byte_idx_r <= 2'd0;
            word_buf_r <= 24'h000000;
            chk_r      <= 8'h00;
        end else if ((state_r == ST_LEN) && rx_valid) begin
            len_r      <= IDX_W'(rx_data);
            word_idx_r <= IDX_ZERO;
            byte_idx_r <= 2'd0;
            chk_r      <= 8'h00;
        end else if ((state_r == ST_DATA) && rx_valid) begin
            chk_r      <= xor_accumulate(chk_r, rx_data);
            byte_idx_r <= byte_idx_r + 2'd1;
            case (byte_idx_r)
                2'd0:    word_buf_r[7:0]   <= rx_data;
                2'd1:    word_buf_r[15:8]  <= rx_data;
                2'd2:    word_buf_r[23:16] <= rx_data;
                default: word_buf_r        <= word_buf_r;
            endcase
            if (word_end_s) begin
                word_idx_r <= word_idx_r + IDX_ONE;
            end else begin
                word_idx_r <= word_idx_r;
            end
        end else begin
            len_r      <= len_r;
            word_idx_r <= word_idx_r;
            byte_idx_r <= byte_idx_r;
            word_buf_r <= word_buf_r;
            chk_r      <= chk_r;
        end
    end

    // Instruction-memory write port: one-cycle strobe per completed word;
    // address and data hold between writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'h00000000;
        end else if (wr_fire_s) begin
            imem_we    <= 1'b1;
            imem_addr  <= word_idx_r[ADDR_W-1:0];
            imem_wdata <= {rx_data, word_buf_r};
        end else begin
            imem_we    <= 1'b0;
            imem_addr  <= imem_addr;
            imem_wdata <= imem_wdata;
        end
    end

    // Status and CPU control, registered from the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_reset  <= 1'b1;
            cpu_enable <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            cpu_reset  <= (state_n != ST_RUN);
            cpu_enable <= (state_n == ST_RUN) && run_req;
            load_done  <= (state_n == ST_RUN);
            load_err   <= (state_n == ST_ERROR);
        end
    end

endmodule

// File: tb/tb_uart_program_loader.sv
// Bench for uart_program_loader: a byte-stream frame model predicts every
// output each cycle; directed frames plus literal expectations pin the model.
module tb_uart_program_loader;

    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int TO    = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          run_req = 1'b0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_reset;
    logic          cpu_enable;
    logic          load_done;
    logic          load_err;

    int errors = 0;
    int checks = 0;

    uart_program_loader #(
        .INSTR_MEM_DEPTH(DEPTH),
        .ADDR_W(AW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx_valid(rx_valid),
        .rx_data(rx_data),
        .run_req(run_req),
        .imem_we(imem_we),
        .imem_addr(imem_addr),
        .imem_wdata(imem_wdata),
        .cpu_reset(cpu_reset),
        .cpu_enable(cpu_enable),
        .load_done(load_done),
        .load_err(load_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 waiting for sync, 1 inside a frame, 2 program running, 3 rejected
    int          m_mode = 0;
    logic [7:0]  m_q[$];
    int          m_idle = 0;
    logic        e_we = 1'b0;
    logic [31:0] e_addr = 32'h0;
    logic [31:0] e_wdata = 32'h0;
    logic        e_creset = 1'b1;
    logic        e_en = 1'b0;
    logic        e_done = 1'b0;
    logic        e_err = 1'b0;

    task automatic model_step();
        int n;
        int sz;
        int pos;
        logic [7:0] x;
        e_we = 1'b0;
        if (m_mode == 0 || m_mode == 3) begin
            if (rx_valid && rx_data == 8'hA5) begin
                m_mode = 1;
                m_q.delete();
                m_idle = 0;
            end
        end else if (m_mode == 1) begin
            if (rx_valid) begin
                m_idle = 0;
                m_q.push_back(rx_data);
                sz = m_q.size();
                n = int'(m_q[0]);
                if (sz == 1) begin
                    if (n == 0 || n > DEPTH) m_mode = 3;
                end else if (sz <= 1 + 4 * n) begin
                    pos = sz - 2;
                    if (pos % 4 == 3) begin
                        e_we    = 1'b1;
                        e_addr  = 32'(pos / 4);
                        e_wdata = {m_q[sz-1], m_q[sz-2], m_q[sz-3], m_q[sz-4]};
                    end
                end else begin
                    x = 8'h00;
                    for (int i = 1; i <= sz - 2; i++) x = x ^ m_q[i];
                    m_mode = (x == rx_data) ? 2 : 3;
                end
            end else begin
                m_idle++;
                if (m_idle == TO) m_mode = 3;
            end
        end
        e_done   = (m_mode == 2);
        e_creset = (m_mode != 2);
        e_en     = (m_mode == 2) && run_req;
        e_err    = (m_mode == 3);
    endtask

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            m_mode = 0; m_q.delete(); m_idle = 0;
            e_we = 1'b0; e_addr = 32'h0; e_wdata = 32'h0;
            e_creset = 1'b1; e_en = 1'b0; e_done = 1'b0; e_err = 1'b0;
        end else begin
            model_step();
        end
    end

    // ---------------- per-cycle compare + write log ----------------
    logic [31:0] wl_addr[$];
    logic [31:0] wl_data[$];

    initial forever begin
        @(negedge clk);
        chk("imem_we",    32'(imem_we),    32'(e_we));
        chk("imem_addr",  32'(imem_addr),  e_addr);
        chk("imem_wdata", imem_wdata,      e_wdata);
        chk("cpu_reset",  32'(cpu_reset),  32'(e_creset));
        chk("cpu_enable", 32'(cpu_enable), 32'(e_en));
        chk("load_done",  32'(load_done),  32'(e_done));
        chk("load_err",   32'(load_err),   32'(e_err));
        if (imem_we === 1'b1) begin
            wl_addr.push_back(32'(imem_addr));
            wl_data.push_back(imem_wdata);
        end
    end

    // ---------------- stimulus ----------------
    logic [7:0] txq[$];

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_list(input int gap);
        for (int i = 0; i < txq.size(); i++) begin
            rx_valid = 1'b1;
            rx_data  = txq[i];
            tick(1);
            rx_valid = 1'b0;
            tick(gap);
        end
        txq.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(1);
        wl_addr.delete();
        wl_data.delete();
    endtask

    initial begin
        tick(3);
        chk("rst_we",     32'(imem_we),    32'h0);
        chk("rst_addr",   32'(imem_addr),  32'h0);
        chk("rst_wdata",  imem_wdata,      32'h0);
        chk("rst_creset", 32'(cpu_reset),  32'h1);
        chk("rst_en",     32'(cpu_enable), 32'h0);
        chk("rst_done",   32'(load_done),  32'h0);
        chk("rst_err",    32'(load_err),   32'h0);
        reset = 1'b0;
        tick(1);

        // Single-word program with gaps between bytes.
        run_req = 1'b1;
        txq = '{8'hA5, 8'h01, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
        send_list(1);
        tick(2);
        chk("s1_nwr",    32'(wl_addr.size()), 32'd1);
        chk("s1_addr",   wl_addr[0], 32'd0);
        chk("s1_data",   wl_data[0], 32'h00000013);
        chk("s1_done",   32'(load_done),  32'h1);
        chk("s1_creset", 32'(cpu_reset),  32'h0);
        chk("s1_en",     32'(cpu_enable), 32'h1);
        run_req = 1'b0;
        tick(2);
        chk("s1_en_off", 32'(cpu_enable), 32'h0);
        run_req = 1'b1;
        tick(2);

        // Two words, back-to-back bytes.
        do_reset();
        txq = '{8'hA5, 8'h02, 8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h44};
        send_list(0);
        tick(2);
        chk("s2_nwr",  32'(wl_addr.size()), 32'd2);
        chk("s2_d0",   wl_data[0], 32'h11223344);
        chk("s2_a1",   wl_addr[1], 32'd1);
        chk("s2_d1",   wl_data[1], 32'hAABBCCDD);
        chk("s2_done", 32'(load_done), 32'h1);

        // Bad checksum, then recovery with a valid frame.
        do_reset();
        txq = '{8'hA5, 8'h02, 8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h45};
        send_list(0);
        tick(2);
        chk("s3_nwr",    32'(wl_addr.size()), 32'd2);
        chk("s3_d1",     wl_data[1], 32'hAABBCCDD);
        chk("s3_err",    32'(load_err),   32'h1);
        chk("s3_creset", 32'(cpu_reset),  32'h1);
        chk("s3_en",     32'(cpu_enable), 32'h0);
        txq = '{8'hA5, 8'h01, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
        send_list(0);
        tick(2);
        chk("s3_rec_done", 32'(load_done), 32'h1);
        chk("s3_rec_err",  32'(load_err),  32'h0);

        // Length limits: 0 and DEPTH+1 are rejected, DEPTH is accepted.
        do_reset();
        txq = '{8'hA5, 8'h00};
        send_list(0);
        tick(2);
        chk("s4_n0_err", 32'(load_err), 32'h1);
        txq = '{8'hA5, 8'h21};
        send_list(0);
        tick(2);
        chk("s4_n33_err", 32'(load_err), 32'h1);
        chk("s4_nwr",     32'(wl_addr.size()), 32'd0);
        txq.push_back(8'hA5);
        txq.push_back(8'h20);
        for (int w = 0; w < DEPTH; w++) begin
            for (int b = 0; b < 4; b++) txq.push_back(8'(w));
        end
        txq.push_back(8'h00);
        send_list(0);
        tick(2);
        chk("s4_full_nwr",  32'(wl_addr.size()), 32'd32);
        chk("s4_last_addr", wl_addr[31], 32'd31);
        chk("s4_last_data", wl_data[31], 32'h1F1F1F1F);
        chk("s4_full_done", 32'(load_done), 32'h1);

        // Inter-byte timeout after five data bytes.
        do_reset();
        txq = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        send_list(0);
        tick(TO - 2);
        chk("s5_err_early", 32'(load_err), 32'h0);
        tick(4);
        chk("s5_err",  32'(load_err), 32'h1);
        chk("s5_nwr",  32'(wl_addr.size()), 32'd1);
        chk("s5_d0",   wl_data[0], 32'h04030201);
        do_reset();
        txq = '{8'h07, 8'h07, 8'h07, 8'h07};
        send_list(0);
        tick(2);
        chk("s5_idle_nwr",  32'(wl_addr.size()), 32'd0);
        chk("s5_idle_err",  32'(load_err),  32'h0);

        // Asynchronous reset in the middle of DATA.
        do_reset();
        txq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
        send_list(0);
        chk("s6_pre_addr", 32'(imem_addr), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("s6_async_addr",   32'(imem_addr),  32'h0);
        chk("s6_async_wdata",  imem_wdata,      32'h0);
        chk("s6_async_creset", 32'(cpu_reset),  32'h1);
        chk("s6_async_err",    32'(load_err),   32'h0);
        tick(1);
        reset = 1'b0;
        tick(1);
        wl_addr.delete();
        wl_data.delete();
        txq = '{8'h33, 8'h44, 8'h11, 8'h22};
        send_list(0);
        tick(2);
        chk("s6_stray_nwr", 32'(wl_addr.size()), 32'd0);

        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_program_loader.md
UART_PROGRAM_LOADER -- requirements
Module: uart_program_loader

Interface
REQ-001 SHALL have parameter INSTR_MEM_DEPTH, default 32: number of 32-bit instruction words.
REQ-002 SHALL have parameter ADDR_W, default 5: instruction address width, with 2^ADDR_W >= INSTR_MEM_DEPTH.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000000: maximum allowed idle clocks between bytes of a frame.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 rx_valid  in  1  one-cycle strobe; rx_data holds a received UART byte.
REQ-007 rx_data  in  8  received byte, sampled only when rx_valid=1.
REQ-008 run_req  in  1  level request that lets the CPU execute once a program is loaded.
REQ-009 imem_we  out  1  instruction-memory write strobe.
REQ-010 imem_addr  out  ADDR_W  instruction-memory word address.
REQ-011 imem_wdata  out  32  instruction word to write.
REQ-012 cpu_reset  out  1  holds the CPU pipeline in reset while high.
REQ-013 cpu_enable  out  1  CPU clock-enable.
REQ-014 load_done  out  1  high while a verified program is resident.
REQ-015 load_err  out  1  high while the last frame was rejected.

Function
REQ-016 SHALL accept frames of the form: 0xA5, N, then 4*N data bytes (each word LSB first), then C, where C is the XOR of all 4*N data bytes.
REQ-017 SHALL implement states IDLE, LEN, DATA, CHECK, RUN and ERROR; all outputs SHALL be registered.
REQ-018 IDLE: on an rx byte 0xA5, SHALL go to LEN; all other bytes SHALL be ignored.
REQ-019 LEN: if N=0 or N>INSTR_MEM_DEPTH, SHALL go to ERROR; otherwise SHALL latch N, clear the word index, byte index and checksum, and go to DATA.
REQ-020 DATA: each byte SHALL be shifted into its byte lane (first byte into [7:0], fourth byte into [31:24]) and XORed into the running checksum.
REQ-021 On the 4th byte of a word, SHALL pulse imem_we for exactly one cycle, in the cycle after that byte's rx_valid, with imem_addr equal to the word index (0-based) and imem_wdata equal to the assembled word.
REQ-022 After the 4th byte of word N-1, SHALL go to CHECK; the final write pulse SHALL still occur.
REQ-023 CHECK: if the byte equals the checksum, SHALL go to RUN; otherwise SHALL go to ERROR.
REQ-024 RUN: SHALL drive cpu_reset=0, load_done=1 and cpu_enable=run_req (registered, 1-cycle lag); RUN SHALL be left only by reset.
REQ-025 ERROR: SHALL drive load_err=1 and cpu_reset=1; on a byte 0xA5, SHALL clear load_err and go to LEN (a new frame).
REQ-026 In every state other than RUN: cpu_reset=1, cpu_enable=0 and load_done=0.
REQ-027 In LEN, DATA and CHECK, an idle counter SHALL reset on each rx_valid; on reaching TIMEOUT_CYCLES with no byte, SHALL go to ERROR.
REQ-028 SHALL accept rx_valid on back-to-back cycles with no byte lost.
REQ-029 imem_we SHALL never be asserted outside a DATA-word completion, and imem_addr SHALL never exceed N-1.
REQ-030 When rx_valid=0, imem_addr and imem_wdata SHALL hold their last values.

Reset
REQ-031 While reset=1, SHALL clear immediately: state=IDLE, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1, cpu_enable=0, load_done=0, load_err=0, and all counters and the checksum.
REQ-032 Reset asserted mid-frame SHALL discard the partial frame; the next frame SHALL start from 0xA5.

Verification
REQ-033 Bytes A5 01 13 00 00 00 13 -> one imem_we: addr 0, data 0x00000013; then load_done=1, cpu_reset=0, and cpu_enable follows run_req=1.
REQ-034 Bytes A5 02 44 33 22 11 DD CC BB AA 44, sent back-to-back -> writes addr0=0x11223344 and addr1=0xAABBCCDD; RUN is reached.
REQ-035 Same frame with checksum 0x45 -> both writes occur, then load_err=1, cpu_reset=1, cpu_enable=0; a following valid frame recovers to RUN.
REQ-036 N=0x00 and N=0x21 (with DEPTH=32) -> ERROR immediately, with no imem_we.
REQ-037 Stall after 5 data bytes for TIMEOUT_CYCLES (set TIMEOUT_CYCLES=16 in the bench) -> load_err=1; 0x07 bytes sent in IDLE are ignored.
REQ-038 Reset pulse during DATA -> all outputs return to reset values asynchronously; subsequent stray data bytes cause no writes.
